// File: rtl/edge_if.sv
// Level-in / pulse-out bundle for edge_detector.
// master drives sig_in; slave returns the edge pulses.
interface edge_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] sig_in;
  logic [WIDTH-1:0] pulse_out_p;
  logic [WIDTH-1:0] pulse_out_n;
  logic             pulse_any;

  modport master (
    output sig_in,
    input  pulse_out_p,
    input  pulse_out_n,
    input  pulse_any
  );

  modport slave (
    input  sig_in,
    output pulse_out_p,
    output pulse_out_n,
    output pulse_any
  );
endinterface

// File: rtl/edge_detector.sv
// Per-bit rising/falling edge pulse generator.
// Define EDGE_SYNC_EN to add a 2-flop input synchronizer.
module edge_detector #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic   clk,
  input logic   rst_n,
  edge_if.slave bus
);

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] sig_dly;

`ifdef EDGE_SYNC_EN
  logic [WIDTH-1:0] sync_m;
  logic [WIDTH-1:0] sync_q;

  // two-stage synchronizer for inputs from another domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      sync_m <= bus.sig_in;
      sync_q <= sync_m;
    end
  end

  assign cur = sync_q;
`else
  assign cur = bus.sig_in;
`endif

  // remember last cycle's level for comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_dly <= RST_VAL;
    else        sig_dly <= cur;
  end

  // edges are combinational and silenced during reset
  always_comb begin
    bus.pulse_out_p = '0;
    bus.pulse_out_n = '0;
    if (rst_n) begin
      bus.pulse_out_p = cur & ~sig_dly;
      bus.pulse_out_n = ~cur & sig_dly;
    end
    bus.pulse_any = |(bus.pulse_out_p | bus.pulse_out_n);
  end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector (WIDTH=1).
// Directed table, hand sequences, then random vs model.
module tb_edge_detector;

  localparam logic RST_VAL = 1'b0;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  logic hist[$];

  edge_if #(.WIDTH(1)) bif ();

  edge_detector #(
    .WIDTH  (1),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic s;
    logic r;
    logic ep;
    logic en;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic chk_all(input string nm, input logic ep,
                         input logic en);
    chk({nm, "_p"}, bif.pulse_out_p[0], ep);
    chk({nm, "_n"}, bif.pulse_out_n[0], en);
    chk({nm, "_any"}, bif.pulse_any, ep | en);
  endtask

  // called just after a posedge; returns just after next posedge
  task automatic apply(input string nm, input logic s,
                       input logic r, input logic ep,
                       input logic en);
    bif.sig_in = s;
    rst_n      = r;
    @(negedge clk);
    chk_all(nm, ep, en);
    if (!r) chk({nm, "_dly"}, dut.sig_dly[0], RST_VAL);
    @(posedge clk);
    #1;
    hist.push_back(r ? s : RST_VAL);
  endtask

  initial begin
    logic s, r, prev, ep, en;
    pass_cnt  = 0;
    total_cnt = 0;

    vt = '{
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1}
    };

    rst_n      = 1'b0;
    bif.sig_in = 1'b0;
    #5;
    chk_all("rst_lo", 1'b0, 1'b0);
    chk("rst_dly", dut.sig_dly[0], RST_VAL);
    #1 bif.sig_in = 1'b1;
    #2;
    chk_all("rst_hi_in", 1'b0, 1'b0);
    #1 bif.sig_in = 1'b0;
    #6 rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_rst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    hist.push_back(1'b0);

    for (int i = 0; i < 19; i++)
      apply($sformatf("vec%0d", i), vt[i].s, vt[i].r,
            vt[i].ep, vt[i].en);

    // reset asserted while a pulse is high
    prev       = hist[$];
    bif.sig_in = ~prev;
    #5;
    chk_all("mid_pre", ~prev, prev);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0);
    chk("mid_dly", dut.sig_dly[0], RST_VAL);
    @(posedge clk);
    #1;
    hist.push_back(RST_VAL);
    apply("mid_hold", bif.sig_in, 1'b0, 1'b0, 1'b0);
    apply("mid_rel", 1'b1, 1'b1, ~RST_VAL, 1'b0);

    // random traffic against a level-history model
    for (int i = 0; i < 300; i++) begin
      s    = 1'($urandom);
      r    = ($urandom_range(0, 15) != 0);
      prev = hist[$];
      ep   = r && (s == 1'b1) && (prev == 1'b0);
      en   = r && (s == 1'b0) && (prev == 1'b1);
      apply($sformatf("rnd%0d", i), s, r, ep, en);
      if (hist.size() > 8) void'(hist.pop_front());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
